timer_intr_gen: RTL

TIMER_INTR_GEN -- requirements
Module: timer_intr_gen

---
 rtl/timer_pkg.sv | 40 ++++
 rtl/timer_prescaler.sv | 42 ++++
 rtl/timer_intr_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register map, field positions and reset constants for the machine timer.
package timer_pkg;

   // Byte offsets of the registers; bits [4:2] select, bits [1:0] are ignored.
   localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
   localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
   localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] OFF_CTRL        = 5'h10;
   localparam logic [4:0] OFF_STATUS      = 5'h14;

   // Word indices derived from the offsets, compared against addr[4:2].
   localparam logic [2:0] IDX_MTIME_LO    = OFF_MTIME_LO[4:2];
   localparam logic [2:0] IDX_MTIME_HI    = OFF_MTIME_HI[4:2];
   localparam logic [2:0] IDX_MTIMECMP_LO = OFF_MTIMECMP_LO[4:2];
   localparam logic [2:0] IDX_MTIMECMP_HI = OFF_MTIMECMP_HI[4:2];
   localparam logic [2:0] IDX_CTRL        = OFF_CTRL[4:2];
   localparam logic [2:0] IDX_STATUS      = OFF_STATUS[4:2];

   // CTRL / STATUS field positions.
   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_PRESC_LSB  = 8;
   localparam int STATUS_PEND_BIT = 0;

   // All-ones compare value keeps match low out of reset.
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   // Replace only the byte lanes enabled in mask.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..PRESC while enabled and emits a tick on the terminal count.
module timer_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               clear_i,
   input  logic [PRESC_W-1:0] presc_i,
   output logic               tick_o
);

   logic [PRESC_W-1:0] count_q;
   logic [PRESC_W-1:0] count_d;

   // Tick reflects the current count; a same-cycle clear only affects the next count.
   assign tick_o = en_i && (count_q == presc_i);

   // Next count: clear wins, terminal count wraps, otherwise advance while enabled.
   always_comb begin
      // NOTE: default assignment first so every path drives count_d and no latch is inferred.
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (tick_o) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: non-blocking assignments so all flops sample pre-edge values together.
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/timer_intr_gen.sv
// Machine-timer peripheral: 64-bit mtime/mtimecmp on a select/strobe bus,
// prescaled time base, sticky pending flag and one-cycle timer interrupt.
module timer_intr_gen
   import timer_pkg::*;
#(
   parameter int DW      = 32,
   parameter int PRESC_W = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          sel_i,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [4:0]    addr_i,
   input  logic [3:0]    mask_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          t_intr
);

   // Architectural state.
   logic [63:0]        mtime_q,  mtime_d;
   logic [31:0]        shadow_q, shadow_d;
   logic [63:0]        cmp_q,    cmp_d;
   logic               en_q,     en_d;
   logic               irq_en_q, irq_en_d;
   logic [PRESC_W-1:0] presc_q,  presc_d;
   logic               pend_q,   pend_d;
   logic               match_q;
   logic               t_intr_q;

   // Decode.
   logic [2:0]  reg_idx;
   logic        wr_en;
   logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;
   logic        snap;
   logic        pend_clr;
   logic [31:0] ctrl_rd;
   logic [31:0] ctrl_wr;

   // Time base and compare.
   logic tick;
   logic match;
   logic rise;

   assign reg_idx     = addr_i[4:2];
   assign wr_en       = sel_i && we_i;
   assign wr_mtime_lo = wr_en && (reg_idx == IDX_MTIME_LO);
   assign wr_mtime_hi = wr_en && (reg_idx == IDX_MTIME_HI);
   assign wr_cmp_lo   = wr_en && (reg_idx == IDX_MTIMECMP_LO);
   assign wr_cmp_hi   = wr_en && (reg_idx == IDX_MTIMECMP_HI);
   assign wr_ctrl     = wr_en && (reg_idx == IDX_CTRL);
   assign wr_status   = wr_en && (reg_idx == IDX_STATUS);
   // A read of MTIME_LO freezes the upper half so the following HI read is coherent.
   assign snap        = sel_i && re_i && (reg_idx == IDX_MTIME_LO);
   assign pend_clr    = wr_status && mask_i[0] && wdata_i[STATUS_PEND_BIT];

   // Assemble the CTRL word from its fields; unlisted bits read as zero.
   always_comb begin
      ctrl_rd                                = '0;
      ctrl_rd[CTRL_EN_BIT]                   = en_q;
      ctrl_rd[CTRL_IRQ_EN_BIT]               = irq_en_q;
      ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]     = presc_q;
   end

   assign ctrl_wr = byte_merge(ctrl_rd, wdata_i, mask_i);

   // Bits that exist on the bus but carry no state in this block.
   logic unused_bits;
   assign unused_bits = ^{addr_i[1:0],
                          ctrl_wr[31:CTRL_PRESC_LSB+PRESC_W],
                          ctrl_wr[CTRL_PRESC_LSB-1:CTRL_IRQ_EN_BIT+1]};

   timer_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_q),
      .clear_i (wr_ctrl),
      .presc_i (presc_q),
      .tick_o  (tick)
   );

   assign match = (mtime_q >= cmp_q);
   assign rise  = match && !match_q;

   // Next-state for the register file: software writes beat the tick increment,
   // and a same-cycle rise beats a PEND clear.
   always_comb begin
      mtime_d  = mtime_q;
      shadow_d = shadow_q;
      cmp_d    = cmp_q;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      presc_d  = presc_q;
      pend_d   = pend_q;

      if (wr_mtime_lo) begin
         mtime_d[31:0] = byte_merge(mtime_q[31:0], wdata_i, mask_i);
      end else if (wr_mtime_hi) begin
         mtime_d[63:32] = byte_merge(mtime_q[63:32], wdata_i, mask_i);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end

      if (snap) begin
         shadow_d = mtime_q[63:32];
      end

      if (wr_cmp_lo) begin
         cmp_d[31:0] = byte_merge(cmp_q[31:0], wdata_i, mask_i);
      end
      if (wr_cmp_hi) begin
         cmp_d[63:32] = byte_merge(cmp_q[63:32], wdata_i, mask_i);
      end

      if (wr_ctrl) begin
         en_d     = ctrl_wr[CTRL_EN_BIT];
         irq_en_d = ctrl_wr[CTRL_IRQ_EN_BIT];
         presc_d  = ctrl_wr[CTRL_PRESC_LSB +: PRESC_W];
      end

      if (rise) begin
         pend_d = 1'b1;
      end else if (pend_clr) begin
         pend_d = 1'b0;
      end
   end

   // State registers; the interrupt is a registered one-cycle copy of an enabled rise.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mtime_q  <= '0;
         shadow_q <= '0;
         cmp_q    <= MTIMECMP_RST;
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         presc_q  <= '0;
         pend_q   <= 1'b0;
         match_q  <= 1'b0;
         t_intr_q <= 1'b0;
      end else begin
         mtime_q  <= mtime_d;
         shadow_q <= shadow_d;
         cmp_q    <= cmp_d;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         presc_q  <= presc_d;
         pend_q   <= pend_d;
         match_q  <= match;
         t_intr_q <= rise && irq_en_q;
      end
   end

   assign t_intr = t_intr_q;

   // Read mux: combinational from addr_i, zero when not selected or unmapped.
   always_comb begin
      rdata_o = '0;
      if (sel_i) begin
         case (reg_idx)
            IDX_MTIME_LO:    rdata_o = mtime_q[31:0];
            IDX_MTIME_HI:    rdata_o = shadow_q;
            IDX_MTIMECMP_LO: rdata_o = cmp_q[31:0];
            IDX_MTIMECMP_HI: rdata_o = cmp_q[63:32];
            IDX_CTRL:        rdata_o = ctrl_rd;
            IDX_STATUS:      rdata_o[STATUS_PEND_BIT] = pend_q;
            default:         rdata_o = '0;
         endcase
      end
   end

endmodule
